// File: rtl/cp0_pkg.sv
// Shared constants, state encoding and register packing helpers for cp0_hilo.
package cp0_pkg;

  // CP0 register numbers
  localparam logic [4:0] REG_BADVADDR = 5'd8;
  localparam logic [4:0] REG_STATUS   = 5'd12;
  localparam logic [4:0] REG_CAUSE    = 5'd13;
  localparam logic [4:0] REG_EPC      = 5'd14;
  localparam logic [4:0] REG_PRID     = 5'd15;

  // ExcCode values
  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;

  // Status bit positions
  localparam int ST_IE    = 0;
  localparam int ST_EXL   = 1;
  localparam int ST_IM_LO = 8;
  localparam int ST_IM_HI = 15;

  // Cause bit positions
  localparam int CA_EXC_LO  = 2;
  localparam int CA_EXC_HI  = 6;
  localparam int CA_IPSW_LO = 8;
  localparam int CA_IPSW_HI = 9;
  localparam int CA_IPHW_LO = 10;
  localparam int CA_IPHW_HI = 15;

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } cp0_state_e;

  // Assemble the architectural Status word; unimplemented bits read as zero.
  function automatic logic [31:0] status_word(input logic [7:0] im,
                                              input logic exl,
                                              input logic ie);
    logic [31:0] w;
    w = 32'd0;
    w[ST_IM_HI:ST_IM_LO] = im;
    w[ST_EXL] = exl;
    w[ST_IE] = ie;
    return w;
  endfunction

  // Assemble the architectural Cause word; unimplemented bits read as zero.
  function automatic logic [31:0] cause_word(input logic [5:0] ip_hw,
                                             input logic [1:0] ip_sw,
                                             input logic [4:0] exc_code);
    logic [31:0] w;
    w = 32'd0;
    w[CA_IPHW_HI:CA_IPHW_LO] = ip_hw;
    w[CA_IPSW_HI:CA_IPSW_LO] = ip_sw;
    w[CA_EXC_HI:CA_EXC_LO] = exc_code;
    return w;
  endfunction

endpackage

// File: rtl/cp0_hilo_intr_sync.sv
// Two-flop synchroniser for the six asynchronous external interrupt lines.
module intr_sync (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] d,
  output logic [5:0] q
);

  logic [5:0] stage1_r;
  logic [5:0] stage2_r;

  // Shift the raw lines through two flops so Cause only ever sees settled values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      stage1_r <= 6'd0;
      stage2_r <= 6'd0;
    end else begin
      stage1_r <= d;
      stage2_r <= stage1_r;
    end
  end

  assign q = stage2_r;

endmodule

// File: rtl/cp0_hilo.sv
// CP0 (Status/Cause/EPC/BadVAddr/PRId) and HI/LO registers with exception,
// interrupt and eret arbitration and a registered one-cycle PC redirect.
module cp0_hilo
  import cp0_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0040,
  parameter logic [31:0] PRID       = 32'h0000_5500
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mtc0,
  input  logic        mfc0,
  input  logic        mthi,
  input  logic        mfhi,
  input  logic        mtlo,
  input  logic        mflo,
  input  logic        c0_eret,
  input  logic [4:0]  reg_d,
  input  logic [31:0] rt2cp0,
  input  logic [31:0] rs2hilo,
  input  logic        add_err,
  input  logic        mem_wr,
  input  logic [31:0] bad_addr,
  input  logic [31:0] epc_pc,
  input  logic [5:0]  intr,
  output logic [31:0] rdfcp0,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        in_handler
);

  cp0_state_e  state_r;
  logic        redirect_valid_r;
  logic [31:0] redirect_pc_r;

  logic [7:0]  im_r;
  logic        exl_r;
  logic        ie_r;
  logic [1:0]  ip_sw_r;
  logic [4:0]  exc_code_r;
  logic [31:0] epc_r;
  logic [31:0] badvaddr_r;
  logic [31:0] hi_r;
  logic [31:0] lo_r;

  logic [5:0]  ip_hw_s;
  logic [31:0] status_word_s;
  logic [31:0] cause_word_s;
  logic        int_pend_s;
  logic        take_exc_s;
  logic        take_eret_s;
  logic        wr_c0_s;
  logic        wr_hilo_s;
  logic [4:0]  exc_code_s;
  logic [31:0] rdata_s;

  intr_sync u_intr_sync (
    .clk (clk),
    .rst (rst),
    .d   (intr),
    .q   (ip_hw_s)
  );

  assign status_word_s = status_word(im_r, exl_r, ie_r);
  assign cause_word_s  = cause_word(ip_hw_s, ip_sw_r, exc_code_r);
  assign int_pend_s    = (|({ip_hw_s, ip_sw_r} & im_r)) & ie_r & ~exl_r;

  // Arbitrate this cycle's events; everything is dropped while flushing the wrong path.
  always_comb begin
    take_exc_s  = 1'b0;
    take_eret_s = 1'b0;
    wr_c0_s     = 1'b0;
    wr_hilo_s   = 1'b0;
    exc_code_s  = EXC_INT;
    if (state_r == RUN) begin
      if (add_err) begin
        take_exc_s = 1'b1;
        exc_code_s = mem_wr ? EXC_ADES : EXC_ADEL;
      end else if (int_pend_s) begin
        take_exc_s = 1'b1;
        exc_code_s = EXC_INT;
      end else if (c0_eret) begin
        // eret drops a same-cycle mtc0 but lets HI/LO writes through
        take_eret_s = 1'b1;
        wr_hilo_s   = 1'b1;
      end else begin
        wr_c0_s   = mtc0;
        wr_hilo_s = 1'b1;
      end
    end else begin
      take_exc_s  = 1'b0;
      take_eret_s = 1'b0;
      wr_c0_s     = 1'b0;
      wr_hilo_s   = 1'b0;
      exc_code_s  = EXC_INT;
    end
  end

  // RUN/FLUSH sequencing and the registered redirect pulse.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r          <= RUN;
      redirect_valid_r <= 1'b0;
      redirect_pc_r    <= 32'd0;
    end else begin
      case (state_r)
        RUN: begin
          if (take_exc_s) begin
            state_r          <= FLUSH;
            redirect_valid_r <= 1'b1;
            redirect_pc_r    <= EXC_VECTOR;
          end else if (take_eret_s) begin
            state_r          <= FLUSH;
            redirect_valid_r <= 1'b1;
            redirect_pc_r    <= epc_r;
          end else begin
            state_r          <= RUN;
            redirect_valid_r <= 1'b0;
          end
        end
        FLUSH: begin
          state_r          <= RUN;
          redirect_valid_r <= 1'b0;
        end
        default: begin
          state_r          <= RUN;
          redirect_valid_r <= 1'b0;
        end
      endcase
    end
  end

  // CP0 register updates: exception capture beats eret, which beats mtc0.
  always_ff @(posedge clk) begin
    if (!rst) begin
      im_r       <= 8'd0;
      exl_r      <= 1'b0;
      ie_r       <= 1'b0;
      ip_sw_r    <= 2'd0;
      exc_code_r <= 5'd0;
      epc_r      <= 32'd0;
      badvaddr_r <= 32'd0;
    end else if (take_exc_s) begin
      epc_r      <= epc_pc;
      exl_r      <= 1'b1;
      exc_code_r <= exc_code_s;
      if (add_err) begin
        badvaddr_r <= bad_addr;
      end
    end else if (take_eret_s) begin
      exl_r <= 1'b0;
    end else if (wr_c0_s) begin
      case (reg_d)
        REG_STATUS: begin
          im_r  <= rt2cp0[ST_IM_HI:ST_IM_LO];
          exl_r <= rt2cp0[ST_EXL];
          ie_r  <= rt2cp0[ST_IE];
        end
        REG_CAUSE: ip_sw_r <= rt2cp0[CA_IPSW_HI:CA_IPSW_LO];
        REG_EPC:   epc_r   <= rt2cp0;
        default:   ;
      endcase
    end
  end

  // HI/LO writes; both may land in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      hi_r <= 32'd0;
      lo_r <= 32'd0;
    end else if (wr_hilo_s) begin
      if (mthi) begin
        hi_r <= rs2hilo;
      end
      if (mtlo) begin
        lo_r <= rs2hilo;
      end
    end
  end

  // Zero-latency read mux, mfc0 over mfhi over mflo; returns pre-write values.
  always_comb begin
    rdata_s = 32'd0;
    if (mfc0) begin
      case (reg_d)
        REG_BADVADDR: rdata_s = badvaddr_r;
        REG_STATUS:   rdata_s = status_word_s;
        REG_CAUSE:    rdata_s = cause_word_s;
        REG_EPC:      rdata_s = epc_r;
        REG_PRID:     rdata_s = PRID;
        default:      rdata_s = 32'd0;
      endcase
    end else if (mfhi) begin
      rdata_s = hi_r;
    end else if (mflo) begin
      rdata_s = lo_r;
    end else begin
      rdata_s = 32'd0;
    end
  end

  assign rdfcp0         = rdata_s;
  assign redirect_valid = redirect_valid_r;
  assign redirect_pc    = redirect_pc_r;
  assign in_handler     = exl_r;

endmodule

// File: tb/tb_cp0_hilo.sv
// Self-checking bench for cp0_hilo: directed vector table, then random traffic
// compared against a word-level reference model.
module tb_cp0_hilo;

  localparam logic [31:0] EXC_VEC = 32'h0000_0040;
  localparam logic [31:0] PRID_V  = 32'h0000_5500;

  // strobe bundle order: {mtc0, mfc0, mthi, mfhi, mtlo, mflo, c0_eret}
  localparam logic [6:0] NONE = 7'b0000000;
  localparam logic [6:0] MTC0 = 7'b1000000;
  localparam logic [6:0] MFC0 = 7'b0100000;
  localparam logic [6:0] MTHI = 7'b0010000;
  localparam logic [6:0] MFHI = 7'b0001000;
  localparam logic [6:0] MTLO = 7'b0000100;
  localparam logic [6:0] MFLO = 7'b0000010;
  localparam logic [6:0] ERET = 7'b0000001;

  typedef struct {
    logic        rst;
    logic [6:0]  strb;
    logic [4:0]  reg_d;
    logic [31:0] rt;
    logic [31:0] rs;
    logic        aerr;
    logic        memwr;
    logic [31:0] bad;
    logic [31:0] epc;
    logic [5:0]  intr;
    logic [31:0] exp_rd;
    logic        exp_rv;
    logic [31:0] exp_rpc;
    logic        exp_inh;
  } vec_t;

  logic        clk;
  logic        rst;
  logic        mtc0, mfc0, mthi, mfhi, mtlo, mflo, c0_eret;
  logic [4:0]  reg_d;
  logic [31:0] rt2cp0, rs2hilo, bad_addr, epc_pc;
  logic        add_err, mem_wr;
  logic [5:0]  intr;
  logic [31:0] rdfcp0;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        in_handler;

  int checks = 0;
  int errors = 0;

  // reference model state (architectural words)
  logic [31:0] m_status, m_cause, m_epc, m_bad, m_hi, m_lo, m_rpc;
  bit          m_flush, m_rv;
  logic [5:0]  intr_q[$];

  vec_t tbl[$];

  cp0_hilo #(.EXC_VECTOR(EXC_VEC), .PRID(PRID_V)) dut (
    .clk            (clk),
    .rst            (rst),
    .mtc0           (mtc0),
    .mfc0           (mfc0),
    .mthi           (mthi),
    .mfhi           (mfhi),
    .mtlo           (mtlo),
    .mflo           (mflo),
    .c0_eret        (c0_eret),
    .reg_d          (reg_d),
    .rt2cp0         (rt2cp0),
    .rs2hilo        (rs2hilo),
    .add_err        (add_err),
    .mem_wr         (mem_wr),
    .bad_addr       (bad_addr),
    .epc_pc         (epc_pc),
    .intr           (intr),
    .rdfcp0         (rdfcp0),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .in_handler     (in_handler)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit has(input logic [6:0] s, input logic [6:0] m);
    return (s & m) != 7'd0;
  endfunction

  function automatic logic [31:0] m_cause_word();
    return (m_cause & 32'h0000_037C) | ({26'd0, intr_q[0]} << 10);
  endfunction

  function automatic logic [31:0] m_read(input vec_t v);
    if (has(v.strb, MFC0)) begin
      case (v.reg_d)
        5'd8:    return m_bad;
        5'd12:   return m_status;
        5'd13:   return m_cause_word();
        5'd14:   return m_epc;
        5'd15:   return PRID_V;
        default: return 32'd0;
      endcase
    end
    if (has(v.strb, MFHI)) return m_hi;
    if (has(v.strb, MFLO)) return m_lo;
    return 32'd0;
  endfunction

  task automatic model_edge(input vec_t v);
    logic [31:0] cw;
    bit pend;
    if (!v.rst) begin
      m_status = 32'd0; m_cause = 32'd0; m_epc = 32'd0; m_bad = 32'd0;
      m_hi = 32'd0; m_lo = 32'd0; m_rpc = 32'd0; m_flush = 1'b0; m_rv = 1'b0;
      intr_q = {6'd0, 6'd0};
    end else begin
      cw = m_cause_word();
      pend = ((cw[15:8] & m_status[15:8]) != 8'd0) && m_status[0] && !m_status[1];
      m_rv = 1'b0;
      if (m_flush) begin
        m_flush = 1'b0;
      end else if (v.aerr || pend) begin
        m_epc = v.epc;
        m_status = m_status | 32'h0000_0002;
        m_cause = (m_cause & ~32'h0000_007C) |
                  ((v.aerr ? (v.memwr ? 32'd5 : 32'd4) : 32'd0) << 2);
        if (v.aerr) m_bad = v.bad;
        m_rv = 1'b1; m_rpc = EXC_VEC; m_flush = 1'b1;
      end else begin
        if (has(v.strb, MTHI)) m_hi = v.rs;
        if (has(v.strb, MTLO)) m_lo = v.rs;
        if (has(v.strb, ERET)) begin
          m_rpc = m_epc; m_rv = 1'b1; m_flush = 1'b1;
          m_status = m_status & ~32'h0000_0002;
        end else if (has(v.strb, MTC0)) begin
          if (v.reg_d == 5'd12) m_status = v.rt & 32'h0000_FF03;
          else if (v.reg_d == 5'd13) m_cause = (m_cause & ~32'h0000_0300) | (v.rt & 32'h0000_0300);
          else if (v.reg_d == 5'd14) m_epc = v.rt;
        end
      end
      intr_q.push_back(v.intr);
      void'(intr_q.pop_front());
    end
  endtask

  task automatic drive(input vec_t v);
    rst = v.rst;
    {mtc0, mfc0, mthi, mfhi, mtlo, mflo, c0_eret} = v.strb;
    reg_d = v.reg_d; rt2cp0 = v.rt; rs2hilo = v.rs;
    add_err = v.aerr; mem_wr = v.memwr; bad_addr = v.bad; epc_pc = v.epc;
    intr = v.intr;
  endtask

  // one clock: check the combinational read before the edge, registered outputs after
  task automatic run_cycle(input vec_t v, input bit use_tbl);
    @(negedge clk);
    drive(v);
    #1;
    chk("rdfcp0", rdfcp0, use_tbl ? v.exp_rd : m_read(v));
    @(posedge clk);
    model_edge(v);
    #1;
    if (use_tbl) begin
      chk("redirect_valid", {31'd0, redirect_valid}, {31'd0, v.exp_rv});
      chk("redirect_pc", redirect_pc, v.exp_rpc);
      chk("in_handler", {31'd0, in_handler}, {31'd0, v.exp_inh});
    end else begin
      chk("redirect_valid", {31'd0, redirect_valid}, {31'd0, m_rv});
      chk("redirect_pc", redirect_pc, m_rpc);
      chk("in_handler", {31'd0, in_handler}, {31'd0, m_status[1]});
    end
  endtask

  function automatic vec_t rand_vec();
    vec_t v;
    logic [4:0] regs [6];
    regs = '{5'd8, 5'd12, 5'd13, 5'd14, 5'd15, 5'd0};
    regs[5] = 5'($urandom_range(0, 31));
    v.rst   = ($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1;
    v.strb  = {($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0),
               ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0),
               ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0),
               ($urandom_range(0, 11) == 0)};
    v.reg_d = regs[$urandom_range(0, 5)];
    v.rt    = $urandom;
    v.rs    = $urandom;
    v.aerr  = ($urandom_range(0, 15) == 0);
    v.memwr = 1'($urandom_range(0, 1));
    v.bad   = $urandom;
    v.epc   = $urandom;
    v.intr  = ($urandom_range(0, 7) == 0) ? 6'($urandom_range(0, 63)) : 6'd0;
    v.exp_rd = 32'd0; v.exp_rv = 1'b0; v.exp_rpc = 32'd0; v.exp_inh = 1'b0;
    return v;
  endfunction

  initial begin
    vec_t rv;
    intr_q = {6'd0, 6'd0};
    m_status = 32'd0; m_cause = 32'd0; m_epc = 32'd0; m_bad = 32'd0;
    m_hi = 32'd0; m_lo = 32'd0; m_rpc = 32'd0; m_flush = 1'b0; m_rv = 1'b0;
    // rst strb reg rt rs aerr memwr bad epc intr | exp_rd rv rpc inh
    tbl.push_back('{0, NONE, 5'd0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0, 6'h0, 32'h0, 0, 32'h0, 0});
    tbl.push_back('{0, NONE, 5'd0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0, 6'h0, 32'h0, 0, 32'h0, 0});
    tbl.push_back('{1, MTHI, 5'd0, 32'h0, 32'hDEAD_BEEF, 0, 0, 32'h0, 32'h0, 6'h0, 32'h0, 0, 32'h0, 0});
    tbl.push_back('{1, MTC0|MFHI, 5'd14, 32'h1234, 32'h0, 0, 0, 32'h0, 32'h0, 6'h0, 32'hDEAD_BEEF, 0, 32'h0, 0});
    tbl.push_back('{1, MFC0, 5'd14, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0, 6'h0, 32'h1234, 0, 32'h0, 0});
    tbl.push_back('{1, MFC0, 5'd15, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0, 6'h0, 32'h5500, 0, 32'h0, 0});
    tbl.push_back('{1, MTHI|MTLO|MFHI, 5'd0, 32'h0, 32'h777, 0, 0, 32'h0, 32'h0, 6'h0, 32'hDEAD_BEEF, 0, 32'h0, 0});
    tbl.push_back('{1, MFLO, 5'd0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0, 6'h0, 32'h777, 0, 32'h0, 0});
    tbl.push_back('{1, MFC0|MFHI|MFLO, 5'd14, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0, 6'h0, 32'h1234, 0, 32'h0, 0});
    tbl.push_back('{1, MTLO|MFLO, 5'd0, 32'h0, 32'h11, 0, 0, 32'h0, 32'h0, 6'h0, 32'h777, 0, 32'h0, 0});
    tbl.push_back('{1, MFHI|MFLO, 5'd0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0, 6'h0, 32'h777, 0, 32'h0, 0});
    tbl.push_back('{1, MFLO, 5'd0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0, 6'h0, 32'h11, 0, 32'h0, 0});
    tbl.push_back('{1, MTC0|MFC0, 5'd3, 32'hFFFF_FFFF, 32'h0, 0, 0, 32'h0, 32'h0, 6'h0, 32'h0, 0, 32'h0, 0});
    tbl.push_back('{1, MFC0, 5'd3, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0, 6'h0, 32'h0, 0, 32'h0, 0});
    tbl.push_back('{1, MTC0|MFC0, 5'd12, 32'hFFFF_FFFF, 32'h0, 0, 0, 32'h0, 32'h0, 6'h0, 32'h0, 0, 32'h0, 1});
    tbl.push_back('{1, MTC0|MFC0, 5'd12, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0, 6'h0, 32'h0000_FF03, 0, 32'h0, 0});
    tbl.push_back('{1, MTC0, 5'd13, 32'hFFFF_FFFF, 32'h0, 0, 0, 32'h0, 32'h0, 6'h0, 32'h0, 0, 32'h0, 0});
    tbl.push_back('{1, MTC0|MFC0, 5'd13, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0, 6'h0, 32'h300, 0, 32'h0, 0});
    // store address error
    tbl.push_back('{1, MFC0, 5'd13, 32'h0, 32'h0, 1, 1, 32'h3, 32'h100, 6'h0, 32'h0, 1, 32'h40, 1});
    tbl.push_back('{1, MFC0, 5'd14, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0, 6'h0, 32'h100, 0, 32'h40, 1});
    tbl.push_back('{1, MFC0, 5'd8, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0, 6'h0, 32'h3, 0, 32'h40, 1});
    tbl.push_back('{1, MFC0, 5'd13, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0, 6'h0, 32'h14, 0, 32'h40, 1});
    // add_err together with eret, mtc0 EPC and mtlo: exception wins, writes dropped
    tbl.push_back('{1, MTC0|ERET|MTLO, 5'd14, 32'hFFFF, 32'hEEE, 1, 0, 32'h11, 32'h300, 6'h0, 32'h0, 1, 32'h40, 1});
    tbl.push_back('{1, MFC0, 5'd14, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0, 6'h0, 32'h300, 0, 32'h40, 1});
    tbl.push_back('{1, MFC0, 5'd13, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0, 6'h0, 32'h10, 0, 32'h40, 1});
    tbl.push_back('{1, MFC0, 5'd8, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0, 6'h0, 32'h11, 0, 32'h40, 1});
    tbl.push_back('{1, MFLO, 5'd0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0, 6'h0, 32'h11, 0, 32'h40, 1});
    // eret: mtc0 dropped, mthi kept, add_err during FLUSH ignored
    tbl.push_back('{1, MTC0, 5'd14, 32'h200, 32'h0, 0, 0, 32'h0, 32'h0, 6'h0, 32'h0, 0, 32'h40, 1});
    tbl.push_back('{1, ERET|MTC0|MFC0|MTHI, 5'd14, 32'h999, 32'h888, 0, 0, 32'h0, 32'h0, 6'h0, 32'h200, 1, 32'h200, 0});
    tbl.push_back('{1, MTHI, 5'd0, 32'h0, 32'hBAD, 1, 0, 32'h77, 32'h500, 6'h0, 32'h0, 0, 32'h200, 0});
    tbl.push_back('{1, MFC0, 5'd14, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0, 6'h0, 32'h200, 0, 32'h200, 0});
    tbl.push_back('{1, MFHI, 5'd0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0, 6'h0, 32'h888, 0, 32'h200, 0});
    tbl.push_back('{1, MFC0, 5'd8, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0, 6'h0, 32'h11, 0, 32'h200, 0});
    // interrupt: IM2 + IE, pulse intr[0], taken on the third edge
    tbl.push_back('{1, MTC0, 5'd12, 32'h401, 32'h0, 0, 0, 32'h0, 32'h0, 6'h0, 32'h0, 0, 32'h200, 0});
    tbl.push_back('{1, MFC0, 5'd12, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0, 6'h1, 32'h401, 0, 32'h200, 0});
    tbl.push_back('{1, NONE, 5'd0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0, 6'h0, 32'h0, 0, 32'h200, 0});
    tbl.push_back('{1, MFC0, 5'd13, 32'h0, 32'h0, 0, 0, 32'h0, 32'h600, 6'h0, 32'h410, 1, 32'h40, 1});
    tbl.push_back('{1, MFC0, 5'd13, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0, 6'h0, 32'h0, 0, 32'h40, 1});
    tbl.push_back('{1, MFC0, 5'd14, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0, 6'h1, 32'h600, 0, 32'h40, 1});
    tbl.push_back('{1, NONE, 5'd0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0, 6'h0, 32'h0, 0, 32'h40, 1});
    tbl.push_back('{1, MFC0, 5'd13, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0, 6'h0, 32'h400, 0, 32'h40, 1});
    tbl.push_back('{1, NONE, 5'd0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0, 6'h0, 32'h0, 0, 32'h40, 1});
    // reset in the redirect cycle
    tbl.push_back('{1, NONE, 5'd0, 32'h0, 32'h0, 1, 0, 32'h9, 32'h700, 6'h0, 32'h0, 1, 32'h40, 1});
    tbl.push_back('{0, NONE, 5'd0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0, 6'h0, 32'h0, 0, 32'h0, 0});
    tbl.push_back('{1, MFC0, 5'd14, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0, 6'h0, 32'h0, 0, 32'h0, 0});
    tbl.push_back('{1, MFC0, 5'd12, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0, 6'h0, 32'h0, 0, 32'h0, 0});
    tbl.push_back('{1, MFHI, 5'd0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0, 6'h0, 32'h0, 0, 32'h0, 0});
    tbl.push_back('{1, MFLO, 5'd0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0, 6'h0, 32'h0, 0, 32'h0, 0});
    tbl.push_back('{1, MFC0, 5'd8, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0, 6'h0, 32'h0, 0, 32'h0, 0});
    tbl.push_back('{1, MFC0, 5'd13, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0, 6'h0, 32'h0, 0, 32'h0, 0});

    for (int i = 0; i < tbl.size(); i++) begin
      run_cycle(tbl[i], 1'b1);
    end

    // randomized traffic against the reference model, starting from reset
    rv = rand_vec();
    rv.rst = 1'b0;
    run_cycle(rv, 1'b0);
    for (int i = 0; i < 3000; i++) begin
      rv = rand_vec();
      run_cycle(rv, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
